// File: rtl/lock_meas_pkg.sv
// ============================================================================
// Module   : lock_meas_pkg
// Brief    : Shared types, defaults and parameter checks for lock_meas_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lock_meas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ARM     = 3'd2,
      ST_WAIT    = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_CAPTURE = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam int DEF_CNT_W = 26;
   localparam int DEF_ACC_W = 32;

   function automatic bit log2_avg_ok(input int l2);
      return (l2 >= 0) && (l2 <= 6);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lock_meas_ctrl.sv
// ============================================================================
// Module   : lock_meas_ctrl
// Brief    : Gates edge inputs into lock_and_count, runs 2^LOG2_AVG
//            measurements per round, reports sum and floored mean.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lock_meas_ctrl
   import lock_meas_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int LOG2_AVG    = 3,
   parameter int ACC_W       = DEF_ACC_W,
   parameter int CLR_CYC     = 2,
   parameter int SETTLE_CYC  = 3,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    continuous,
   input  logic                    abort,
   input  logic                    in_a_raw,
   input  logic                    in_b_raw,
   output logic                    meas_a,
   output logic                    meas_b,
   output logic                    meas_clrn,
   input  logic signed [CNT_W-1:0] meas_result,
   input  logic                    meas_stop,
   input  logic                    meas_overflow,
   output logic                    busy,
   output logic                    sample_valid,
   output logic signed [CNT_W-1:0] sample,
   output logic [LOG2_AVG:0]       sample_idx,
   output logic                    avg_valid,
   output logic signed [ACC_W-1:0] sum,
   output logic signed [CNT_W-1:0] avg,
   output logic                    err_overflow,
   output logic                    err_timeout
);

   localparam int c_TMR_MAX0 = (TIMEOUT_CYC > CLR_CYC) ? TIMEOUT_CYC : CLR_CYC;
   localparam int c_TMR_MAX  = (c_TMR_MAX0 > SETTLE_CYC) ? c_TMR_MAX0 : SETTLE_CYC;
   localparam int c_TMR_W    = $clog2(c_TMR_MAX + 1);
   localparam int c_IDX_W    = LOG2_AVG + 1;

   localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);
   localparam logic [c_TMR_W-1:0] c_TMR_CLR    = c_TMR_W'(CLR_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_TMR_SETTLE = c_TMR_W'(SETTLE_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_TMR_TO     = c_TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'((2 ** LOG2_AVG) - 1);

   generate
      if (!log2_avg_ok(LOG2_AVG) || (ACC_W < CNT_W + LOG2_AVG)) begin : g_bad_params
         $error("lock_meas_ctrl: illegal LOG2_AVG/ACC_W combination");
      end
   endgenerate

   state_t                    r_state_q, w_state_d;
   logic [c_TMR_W-1:0]        r_tmr_q, w_tmr_d;
   logic                      r_gate_q, w_gate_d;
   logic signed [ACC_W-1:0]   r_acc_q, w_acc_d;
   logic [c_IDX_W-1:0]        r_idx_q, w_idx_d;
   logic signed [CNT_W-1:0]   r_sample_q, w_sample_d;
   logic signed [ACC_W-1:0]   r_sum_q, w_sum_d;
   logic signed [CNT_W-1:0]   r_avg_q, w_avg_d;
   logic                      r_sample_valid_q, w_sample_valid_d;
   logic                      r_avg_valid_q, w_avg_valid_d;
   logic                      r_err_ovf_q, w_err_ovf_d;
   logic                      r_err_to_q, w_err_to_d;

   always_comb begin
      w_state_d        = r_state_q;
      w_tmr_d          = r_tmr_q;
      w_gate_d         = 1'b0;
      w_acc_d          = r_acc_q;
      w_idx_d          = r_idx_q;
      w_sample_d       = r_sample_q;
      w_sum_d          = r_sum_q;
      w_avg_d          = r_avg_q;
      w_sample_valid_d = 1'b0;
      w_avg_valid_d    = 1'b0;
      w_err_ovf_d      = r_err_ovf_q;
      w_err_to_d       = r_err_to_q;

      case (r_state_q)
         ST_IDLE: begin
            if (start) begin
               w_acc_d     = '0;
               w_idx_d     = '0;
               w_err_ovf_d = 1'b0;
               w_err_to_d  = 1'b0;
               w_tmr_d     = c_TMR_CLR;
               w_state_d   = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (r_tmr_q == '0) w_state_d = ST_ARM;
            else               w_tmr_d   = r_tmr_q - c_TMR_ONE;
         end
         ST_ARM: begin
            w_tmr_d   = c_TMR_TO;
            w_gate_d  = 1'b1;
            w_state_d = ST_WAIT;
         end
         ST_WAIT: begin
            w_gate_d = 1'b1;
            // Overflow outranks a coincident stop: the result is not trustworthy.
            if (meas_overflow) begin
               w_gate_d    = 1'b0;
               w_err_ovf_d = 1'b1;
               w_state_d   = ST_IDLE;
            end else if (meas_stop) begin
               w_gate_d  = 1'b0;
               w_tmr_d   = c_TMR_SETTLE;
               w_state_d = ST_SETTLE;
            end else if (r_tmr_q == '0) begin
               w_gate_d   = 1'b0;
               w_err_to_d = 1'b1;
               w_state_d  = ST_IDLE;
            end else begin
               w_tmr_d = r_tmr_q - c_TMR_ONE;
            end
         end
         ST_SETTLE: begin
            if (r_tmr_q == '0) w_state_d = ST_CAPTURE;
            else               w_tmr_d   = r_tmr_q - c_TMR_ONE;
         end
         ST_CAPTURE: begin
            w_sample_d       = meas_result;
            w_acc_d          = r_acc_q + ACC_W'(meas_result);
            w_sample_valid_d = 1'b1;
            if (r_idx_q == c_IDX_LAST) begin
               w_state_d = ST_DONE;
            end else begin
               w_idx_d   = r_idx_q + c_IDX_ONE;
               w_tmr_d   = c_TMR_CLR;
               w_state_d = ST_CLEAR;
            end
         end
         ST_DONE: begin
            // Output sum is separate from the accumulator so it stays stable
            // while a continuous round restarts accumulation.
            w_sum_d       = r_acc_q;
            w_avg_d       = CNT_W'(r_acc_q >>> LOG2_AVG);
            w_avg_valid_d = 1'b1;
            if (continuous) begin
               w_acc_d     = '0;
               w_idx_d     = '0;
               w_err_ovf_d = 1'b0;
               w_err_to_d  = 1'b0;
               w_tmr_d     = c_TMR_CLR;
               w_state_d   = ST_CLEAR;
            end else begin
               w_state_d = ST_IDLE;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase

      if (abort) begin
         w_state_d        = ST_IDLE;
         w_gate_d         = 1'b0;
         w_acc_d          = r_acc_q;
         w_idx_d          = r_idx_q;
         w_sample_d       = r_sample_q;
         w_sum_d          = r_sum_q;
         w_avg_d          = r_avg_q;
         w_sample_valid_d = 1'b0;
         w_avg_valid_d    = 1'b0;
         w_err_ovf_d      = r_err_ovf_q;
         w_err_to_d       = r_err_to_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q        <= ST_IDLE;
         r_tmr_q          <= '0;
         r_gate_q         <= 1'b0;
         r_acc_q          <= '0;
         r_idx_q          <= '0;
         r_sample_q       <= '0;
         r_sum_q          <= '0;
         r_avg_q          <= '0;
         r_sample_valid_q <= 1'b0;
         r_avg_valid_q    <= 1'b0;
         r_err_ovf_q      <= 1'b0;
         r_err_to_q       <= 1'b0;
      end else begin
         r_state_q        <= w_state_d;
         r_tmr_q          <= w_tmr_d;
         r_gate_q         <= w_gate_d;
         r_acc_q          <= w_acc_d;
         r_idx_q          <= w_idx_d;
         r_sample_q       <= w_sample_d;
         r_sum_q          <= w_sum_d;
         r_avg_q          <= w_avg_d;
         r_sample_valid_q <= w_sample_valid_d;
         r_avg_valid_q    <= w_avg_valid_d;
         r_err_ovf_q      <= w_err_ovf_d;
         r_err_to_q       <= w_err_to_d;
      end
   end

   assign meas_a       = in_a_raw & r_gate_q;
   assign meas_b       = in_b_raw & r_gate_q;
   assign meas_clrn    = (r_state_q != ST_IDLE) && (r_state_q != ST_CLEAR);
   assign busy         = (r_state_q != ST_IDLE);
   assign sample_valid = r_sample_valid_q;
   assign sample       = r_sample_q;
   assign sample_idx   = r_idx_q;
   assign avg_valid    = r_avg_valid_q;
   assign sum          = r_sum_q;
   assign avg          = r_avg_q;
   assign err_overflow = r_err_ovf_q;
   assign err_timeout  = r_err_to_q;

endmodule

`default_nettype wire
